// File: rtl/mem_lat_bank_if.sv
// Request/response bus for mem_lat_bank: valid/ready request, one-cycle response pulse.
interface mem_lat_bank_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   dout;

  modport master (
    output req_valid, req_write, addr, din, wstrb,
    input  req_ready, resp_valid, dout
  );

  modport slave (
    input  req_valid, req_write, addr, din, wstrb,
    output req_ready, resp_valid, dout
  );
endinterface

// File: rtl/mem_lat_bank.sv
// Multi-cycle line-wide data memory: one outstanding request, fixed LATENCY,
// per-byte write strobes, one-cycle completion pulse for reads and writes.
module mem_lat_bank #(
  parameter int unsigned MEM_DEPTH  = 16384,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic           clk,
  input  logic           reset,
  mem_lat_bank_if.slave  bus
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OFS_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic                    lat_write;
  logic [IDX_W-1:0]        lat_idx;
  logic [DATA_WIDTH-1:0]   lat_din;
  logic [NBYTES-1:0]       lat_wstrb;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    accept;
  logic                    enter_resp;
  logic                    unused_addr_bits;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  assign unused_addr_bits = ^{bus.addr[31:OFS_W+IDX_W], bus.addr[OFS_W-1:0]};

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (state == BUSY) && (cnt == '0);

  // BUSY always lasts LATENCY cycles, so the response follows acceptance
  // by exactly LATENCY edges even when LATENCY is 1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) state_d = RESP;
        else           cnt_d   = cnt - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_din   <= '0;
      lat_wstrb <= '0;
      dout_q    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_idx   <= bus.addr[OFS_W +: IDX_W];
        lat_din   <= bus.din;
        lat_wstrb <= bus.wstrb;
      end
      // Captured line is held only through RESP; zero everywhere else.
      dout_q <= (enter_resp && !lat_write) ? mem[lat_idx] : '0;
    end
  end

  // Storage is not reset; a write only lands on the BUSY->RESP edge.
  always_ff @(posedge clk) begin
    if (enter_resp && lat_write) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (lat_wstrb[i]) mem[lat_idx][8*i +: 8] <= lat_din[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.dout       = dout_q;
endmodule

// File: tb/tb_mem_lat_bank.sv
// Directed self-checking bench for mem_lat_bank: a 32-bit/LATENCY=4/16-line
// instance and a 128-bit/LATENCY=1 instance sharing clock and reset.
module tb_mem_lat_bank;
  localparam int LAT_A = 4;
  localparam logic [127:0] LINE_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_lat_bank_if #(.DATA_WIDTH(32))  bus_a ();
  mem_lat_bank_if #(.DATA_WIDTH(128)) bus_b ();

  mem_lat_bank #(.MEM_DEPTH(16), .DATA_WIDTH(32), .LATENCY(LAT_A), .INIT_FILE("")) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  mem_lat_bank #(.MEM_DEPTH(16384), .DATA_WIDTH(128), .LATENCY(1), .INIT_FILE("")) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction on bus_a with cycle-exact checking of the response.
  // presented: request already on the bus (chained from a held request).
  // bp: keep req_valid high with junk during BUSY/RESP, then present the next request.
  task automatic txn_a(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp,
                       input bit presented, input bit bp);
    int          resp_at;
    int          resp_cnt;
    logic [31:0] pulse_dout;
    logic        stray;
    logic        ready_after;
    resp_at     = -1;
    resp_cnt    = 0;
    pulse_dout  = '0;
    stray       = 1'b0;
    ready_after = 1'b0;
    if (!presented) begin
      @(negedge clk);
      bus_a.req_valid = 1'b1;
      bus_a.req_write = wr;
      bus_a.addr      = a;
      bus_a.din       = d;
      bus_a.wstrb     = s;
    end
    check({tag, "_ready"}, 128'(bus_a.req_ready), 128'(1'b1));
    for (int j = 0; j <= LAT_A + 1; j++) begin
      @(negedge clk);
      if (bus_a.resp_valid) begin
        if (resp_at < 0) resp_at = j;
        resp_cnt++;
        pulse_dout = bus_a.dout;
      end else if (bus_a.dout !== '0) begin
        stray = 1'b1;
      end
      if (j == LAT_A + 1) ready_after = bus_a.req_ready;
      else if (bus_a.req_ready !== 1'b0) stray = 1'b1;
      if (bp) begin
        if (j <= LAT_A) begin
          bus_a.req_write = 1'b1;
          bus_a.addr      = 32'h24;
          bus_a.din       = $urandom;
          bus_a.wstrb     = 4'hF;
        end else begin
          bus_a.req_write = 1'b1;
          bus_a.addr      = 32'h08;
          bus_a.din       = 32'h0BAD_F00D;
          bus_a.wstrb     = 4'hF;
        end
      end else if (j == 0) begin
        bus_a.req_valid = 1'b0;
      end
    end
    check({tag, "_lat"},   128'(resp_at),     128'(LAT_A));
    check({tag, "_pulse"}, 128'(resp_cnt),    128'(1));
    check({tag, "_dout"},  128'(pulse_dout),  128'(exp));
    check({tag, "_quiet"}, 128'(stray),       128'(1'b0));
    check({tag, "_rdy"},   128'(ready_after), 128'(1'b1));
  endtask

  task automatic txn_b(input string tag, input logic wr, input logic [31:0] a,
                       input logic [127:0] d, input logic [127:0] exp);
    @(negedge clk);
    bus_b.req_valid = 1'b1;
    bus_b.req_write = wr;
    bus_b.addr      = a;
    bus_b.din       = d;
    bus_b.wstrb     = '1;
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    check({tag, "_busy"}, 128'({bus_b.req_ready, bus_b.resp_valid}), 128'(2'b00));
    check({tag, "_dz0"},  bus_b.dout, '0);
    @(negedge clk);
    check({tag, "_resp"}, 128'({bus_b.req_ready, bus_b.resp_valid}), 128'(2'b01));
    check({tag, "_dout"}, bus_b.dout, exp);
    @(negedge clk);
    check({tag, "_idle"}, 128'({bus_b.req_ready, bus_b.resp_valid}), 128'(2'b10));
    check({tag, "_dz1"},  bus_b.dout, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.addr = '0; bus_a.din = '0; bus_a.wstrb = '0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.addr = '0; bus_b.din = '0; bus_b.wstrb = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 128'(bus_a.req_ready),  128'(1'b1));
    check("rst_resp",  128'(bus_a.resp_valid), 128'(1'b0));
    check("rst_dout",  128'(bus_a.dout),       128'(0));

    // basic write/read
    txn_a("wr40", 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    txn_a("rd40", 1'b0, 32'h40, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    // byte lanes and empty strobe
    txn_a("wr10a", 1'b1, 32'h10, 32'h1122_3344, 4'hF,    32'h0, 1'b0, 1'b0);
    txn_a("wr10b", 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1'b0);
    txn_a("rd10",  1'b0, 32'h10, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0, 1'b0);
    txn_a("wr10z", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0,    32'h0, 1'b0, 1'b0);
    txn_a("rd10z", 1'b0, 32'h10, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0, 1'b0);
    // wrap-around: addr 0x44 is line 17 -> line 1
    txn_a("wr44", 1'b1, 32'h44, 32'h5, 4'hF, 32'h0, 1'b0, 1'b0);
    txn_a("rd04", 1'b0, 32'h04, 32'h0, 4'h0, 32'h5, 1'b0, 1'b0);
    // back-pressure: junk to 0x24 during BUSY/RESP must never land
    txn_a("wr24", 1'b1, 32'h24, 32'h2424_2424, 4'hF, 32'h0, 1'b0, 1'b0);
    txn_a("bp0c", 1'b1, 32'h0C, 32'h0000_0077, 4'hF, 32'h0, 1'b0, 1'b1);
    txn_a("bp08", 1'b1, 32'h08, 32'h0,         4'h0, 32'h0, 1'b1, 1'b0);
    txn_a("rd0c", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0000_0077, 1'b0, 1'b0);
    txn_a("rd24", 1'b0, 32'h24, 32'h0, 4'h0, 32'h2424_2424, 1'b0, 1'b0);
    txn_a("rd08", 1'b0, 32'h08, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0);

    // reset while BUSY on a write to 0x80 (line 0, holds 0xDEADBEEF)
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.addr = 32'h80;
    bus_a.din = 32'hFFFF_FFFF; bus_a.wstrb = 4'hF;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    check("mid_busy", 128'(bus_a.req_ready), 128'(1'b0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(bus_a.req_ready),  128'(1'b1));
    check("mid_rst_resp",  128'(bus_a.resp_valid), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (LAT_A + 3) begin
      @(negedge clk);
      if (bus_a.resp_valid) saw = 1'b1;
    end
    check("mid_no_resp", 128'(saw), 128'(1'b0));
    txn_a("rd80", 1'b0, 32'h80, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // 128-bit, LATENCY=1: offset bits ignored
    txn_b("b_wr1f", 1'b1, 32'h1F, LINE_B, '0);
    txn_b("b_rd10", 1'b0, 32'h10, '0,     LINE_B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
